instruction_loader: RTL and testbench

//   Writer side of the instruction memory load port. Receives a program as a

---
 rtl/instruction_loader.sv | 114 +++++++++++
 tb/tb_instruction_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction memory loader: packs a received byte stream (MSB first) into
// 32-bit words and writes them with a one-cycle strobe to consecutive word
// addresses. A load ends after the HALT word is written or the memory fills.
module instruction_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_Load_enable,
    output logic [31:0] o_Write_reg,
    output logic [31:0] o_Write_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun,
    output logic [31:0] o_word_count
);

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] shift;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] next_word;

    // Word as it looks once the byte on i_rx_data is shifted in.
    assign next_word = {shift[23:0], i_rx_data};

    // Load sequencer; every output is registered and set on the edge that
    // enters the state it belongs to, so the write strobe is exactly the
    // WRITE cycle and ready is exactly the RECV cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            shift         <= '0;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            o_rx_ready    <= 1'b0;
            o_Load_enable <= 1'b0;
            o_Write_reg   <= '0;
            o_Write_data  <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overrun     <= 1'b0;
            o_word_count  <= '0;
        end else begin
            o_Load_enable <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state        <= RECV;
                        byte_cnt     <= '0;
                        word_cnt     <= '0;
                        o_word_count <= '0;
                        o_done       <= 1'b0;
                        o_busy       <= 1'b1;
                        o_rx_ready   <= 1'b1;
                        // A byte arriving with the start pulse is still dropped.
                        o_overrun    <= i_rx_valid;
                    end else if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                RECV: begin
                    if (i_rx_valid) begin
                        shift <= next_word;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt      <= '0;
                            state         <= WRITE;
                            o_rx_ready    <= 1'b0;
                            o_Load_enable <= 1'b1;
                            o_Write_reg   <= word_cnt;
                            o_Write_data  <= next_word;
                            o_word_count  <= word_cnt + 32'd1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                    // Stop on HALT or at the last address; never wrap.
                    if (shift == HALT_WORD || word_cnt == LAST_ADDR) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        word_cnt   <= word_cnt + 32'd1;
                        state      <= RECV;
                        o_rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a behavioural model of the load
// protocol checked against the DUT every cycle, plus literal expectations.
module tb_instruction_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        load_enable;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;

    instruction_loader #(.DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_rx_ready    (rx_ready),
        .o_Load_enable (load_enable),
        .o_Write_reg   (write_reg),
        .o_Write_data  (write_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_overrun     (overrun),
        .o_word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes collect in a queue; a full queue of four becomes
    // one write cycle; after the write the load either ends or resumes.
    bit          model_on = 0;
    logic [7:0]  m_bytes[$];
    int          m_words;
    bit          m_accepting, m_writing, m_busy, m_done, m_ovr;
    logic [31:0] m_addr, m_data, m_wc;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1;
            m_bytes.delete();
            m_words = 0;
            m_accepting = 0; m_writing = 0; m_busy = 0; m_done = 0; m_ovr = 0;
            m_addr = '0; m_data = '0; m_wc = '0;
        end else if (model_on) begin
            if (m_writing) begin
                m_writing = 0;
                if (rx_valid) m_ovr = 1;
                if (m_data == HALT || m_words == DEPTH) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_accepting = 1;
                end
            end else if (m_accepting) begin
                if (rx_valid) begin
                    m_bytes.push_back(rx_data);
                    if (m_bytes.size() == 4) begin
                        m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_addr = 32'(m_words);
                        m_words++;
                        m_wc = 32'(m_words);
                        m_bytes.delete();
                        m_accepting = 0;
                        m_writing = 1;
                    end
                end
            end else if (start) begin
                m_bytes.delete();
                m_words = 0; m_wc = '0;
                m_accepting = 1; m_busy = 1; m_done = 0;
                m_ovr = rx_valid;
            end else if (rx_valid) begin
                m_ovr = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("rx_ready",    {31'd0, rx_ready},    {31'd0, m_accepting});
            chk("load_enable", {31'd0, load_enable}, {31'd0, m_writing});
            chk("write_reg",   write_reg,            m_addr);
            chk("write_data",  write_data,           m_data);
            chk("busy",        {31'd0, busy},        {31'd0, m_busy});
            chk("done",        {31'd0, done},        {31'd0, m_done});
            chk("overrun",     {31'd0, overrun},     {31'd0, m_ovr});
            chk("word_count",  word_count,           m_wc);
        end
    end

    // Record of every write the memory would see.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    always @(negedge clk) begin
        if (load_enable === 1'b1) begin
            log_addr.push_back(write_reg);
            log_data.push_back(write_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic raw_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        while (rx_ready !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: rx_ready %b required 1", rx_ready);
        end else begin
            raw_byte(b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx >= log_addr.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: write %0d missing, log holds %0d", name, idx, log_addr.size());
        end else begin
            chk({name, "_addr"}, log_addr[idx], a);
            chk({name, "_data"}, log_data[idx], d);
        end
    endtask

    int base;

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_wreg",  write_reg,         32'd0);
        step(1);

        // Two words then HALT.
        pulse_start();
        base = log_addr.size();
        send_word(32'h2008_0005);
        send_word(32'h8C09_0004);
        step(1);
        chk_log("t1_w0", base,     32'd0, 32'h2008_0005);
        chk_log("t1_w1", base + 1, 32'd1, 32'h8C09_0004);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'hFFFF_FFFF);
        step(2);
        chk_log("t2_halt", base + 2, 32'd2, 32'hFFFF_FFFF);
        chk("t2_done",  {31'd0, done},     32'd1);
        chk("t2_count", word_count,        32'd3);
        chk("t2_ready", {31'd0, rx_ready}, 32'd0);

        // Fill the whole memory, then try a 33rd word.
        pulse_start();
        base = log_addr.size();
        for (int i = 0; i < DEPTH; i++) send_word(32'h0010_0000 + 32'(i));
        step(2);
        chk("t3_nwrites", 32'(log_addr.size() - base), 32'd32);
        chk_log("t3_last", base + 31, 32'd31, 32'h0010_001F);
        chk("t3_done",  {31'd0, done}, 32'd1);
        chk("t3_count", word_count,    32'd32);
        for (int i = 0; i < 4; i++) raw_byte(8'h5A);
        step(1);
        chk("t3_nostrobe", 32'(log_addr.size() - base), 32'd32);
        chk("t3_overrun",  {31'd0, overrun},            32'd1);

        // Restart from DONE, start while busy, byte on the write cycle.
        pulse_start();
        chk("t6_done",    {31'd0, done},    32'd0);
        chk("t6_overrun", {31'd0, overrun}, 32'd0);
        chk("t6_count",   word_count,       32'd0);
        base = log_addr.size();
        send_byte(8'hDE);
        send_byte(8'hAD);
        pulse_start();
        send_byte(8'hBE);
        send_byte(8'hEF);
        raw_byte(8'hAA);
        send_word(32'h1122_3344);
        step(1);
        chk_log("t6_w0", base,     32'd0, 32'hDEAD_BEEF);
        chk_log("t4_w1", base + 1, 32'd1, 32'h1122_3344);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        send_word(HALT);
        step(2);

        // Reset in the middle of a word, then reload.
        pulse_start();
        base = log_addr.size();
        send_word(32'hA0A0_A0A0);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy",  {31'd0, busy},  32'd0);
        chk("t5_wdata", write_data,     32'd0);
        chk("t5_count", word_count,     32'd0);
        step(1);
        pulse_start();
        send_word(32'h1234_5678);
        step(1);
        chk("t5_nwrites", 32'(log_addr.size() - base), 32'd2);
        chk_log("t5_reload", base + 1, 32'd0, 32'h1234_5678);
        send_word(HALT);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
